// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: default operand width,
// opcode encoding and FSM state encoding.
// Optional feature macro: ALU_DIV_EN (enables the iterative divide datapath).
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath shared by MUL (shift-add) and DIV (restoring division).
// One bit is processed per step; after WIDTH steps the step_* outputs hold
// the final {high, low} pair. step_* are the values the registers would take
// on this step, so the parent can capture the result on the last step.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               load operands (a, b) and the operation kind
//   step                perform one iteration
//   finish              final step: parent captures step_*, engine clears
//   op_div              1 = divide, 0 = multiply (only with ALU_DIV_EN)
//   a, b                operands
//   step_lo, step_hi    product low/high, or quotient/remainder
//   step_carry          multiply: high half non-zero; divide: 0
// The divide datapath exists only when ALU_DIV_EN is defined.
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic             finish,
`ifdef ALU_DIV_EN
  input  logic             op_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] step_lo,
  output logic [WIDTH-1:0] step_hi,
  output logic             step_carry
);

  // hi: product accumulator / partial remainder
  // lo: multiplier being shifted out, product low bits shifted in /
  //     dividend being shifted out, quotient bits shifted in
  // opnd: multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi    = mul_sum[WIDTH:1];
    step_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    step_carry = (step_hi != '0);
`ifdef ALU_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      step_carry = 1'b0;
      // Top bit of the difference set means the trial subtraction borrowed:
      // restore (keep the shifted remainder) and shift in a 0 quotient bit.
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
`ifdef ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start) begin
      hi_d = '0;
`ifdef ALU_DIV_EN
      div_d  = op_div;
      lo_d   = op_div ? a : b;
      opnd_d = op_div ? b : a;
`else
      lo_d   = b;
      opnd_d = a;
`endif
    end else if (finish) begin
      hi_d   = '0;
      lo_d   = '0;
      opnd_d = '0;
`ifdef ALU_DIV_EN
      div_d  = 1'b0;
`endif
    end else if (step) begin
      hi_d = step_hi;
      lo_d = step_lo;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
`ifdef ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU. ADD/SUB/AND/OR/XOR/SHL complete one cycle after accept;
// MUL (and DIV with a non-zero divisor) spend WIDTH cycles in BUSY in
// alu_iter_engine. Results and flags hold from one done pulse to the next.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               request; accepted in IDLE or DONE, ignored in BUSY
//   opcode, a, b        operation and operands, captured at accept
//   busy                high exactly while in BUSY
//   done                one-cycle pulse when results become valid
//   result, result_hi   low result; product high half or remainder
//   zero, carry, err    status flags
// Configuration macro: ALU_DIV_EN. When undefined, opcode 7 is illegal and
// completes in one cycle with err=1 and zero results.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  opcode_t          op;
  logic             accept;
  logic             iter_op;
  logic             iter_start;
  logic             iter_step;
  logic             iter_finish;
  logic [WIDTH-1:0] eng_lo, eng_hi;
  logic             eng_carry;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH-1:0] fast_lo, fast_hi;
  logic             fast_c, fast_e;

  assign op     = opcode_t'(opcode);
  assign accept = start && (state_q != ST_BUSY);

  // A zero divisor never enters the iteration; it completes immediately.
`ifdef ALU_DIV_EN
  assign iter_op = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
  assign iter_op = (op == OP_MUL);
`endif

  assign iter_start  = accept && iter_op;
  assign iter_step   = (state_q == ST_BUSY);
  assign iter_finish = iter_step && (cnt_q == CNT_W'(WIDTH - 1));

  alu_iter_engine #(
    .WIDTH      (WIDTH)
  ) u_engine (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (iter_start),
    .step       (iter_step),
    .finish     (iter_finish),
`ifdef ALU_DIV_EN
    .op_div     (op == OP_DIV),
`endif
    .a          (a),
    .b          (b),
    .step_lo    (eng_lo),
    .step_hi    (eng_hi),
    .step_carry (eng_carry)
  );

  // Single-cycle results, evaluated on the live operands at the accept edge.
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    // Bit WIDTH of the widened shift is the last bit shifted out (0 for shift 0).
    shl_ext = {1'b0, a} << b[3:0];
    fast_lo = '0;
    fast_hi = '0;
    fast_c  = 1'b0;
    fast_e  = 1'b0;
    case (op)
      OP_ADD: {fast_c, fast_lo} = add_ext;
      OP_SUB: begin
        fast_lo = a - b;
        fast_c  = (a < b);
      end
      OP_AND: fast_lo = a & b;
      OP_OR:  fast_lo = a | b;
      OP_XOR: fast_lo = a ^ b;
      OP_SHL: begin
        fast_lo = shl_ext[WIDTH-1:0];
        fast_c  = shl_ext[WIDTH];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        fast_lo = '1;
        fast_hi = a;
        fast_e  = 1'b1;
      end
`else
      OP_DIV: fast_e = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    err_d       = err_q;
    if (iter_finish) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      result_d    = eng_lo;
      result_hi_d = eng_hi;
      zero_d      = (eng_lo == '0);
      carry_d     = eng_carry;
      err_d       = 1'b0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (accept) begin
      if (iter_op) begin
        state_d = ST_BUSY;
        cnt_d   = '0;
      end else begin
        state_d     = ST_DONE;
        done_d      = 1'b1;
        result_d    = fast_lo;
        result_hi_d = fast_hi;
        zero_d      = (fast_lo == '0);
        carry_d     = fast_c;
        err_d       = fast_e;
      end
    end else begin
      state_d = ST_IDLE;
    end
    busy_d = (state_d == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=16). Expected values come
// from a plain-arithmetic reference model; works with or without ALU_DIV_EN.
module tb_multicycle_alu;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zero;
  logic        carry;
  logic        err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] last_lo  = 16'h0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        z;
    logic        c;
    logic        e;
    int          lat;
  } exp_t;

  multicycle_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .carry     (carry),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: what the ALU should report for one operation.
  function automatic exp_t model(input int op, input logic [15:0] av, input logic [15:0] bv);
    exp_t        e;
    int unsigned x;
    int unsigned y;
    int unsigned full;
    int          sh;
    x     = 32'(av);
    y     = 32'(bv);
    e.lo  = 16'h0;
    e.hi  = 16'h0;
    e.c   = 1'b0;
    e.e   = 1'b0;
    e.lat = 1;
    case (op)
      0: begin full = x + y; e.lo = full[15:0]; e.c = full[16]; end
      1: begin full = x - y; e.lo = full[15:0]; e.c = (x < y); end
      2: begin full = x & y; e.lo = full[15:0]; end
      3: begin full = x | y; e.lo = full[15:0]; end
      4: begin full = x ^ y; e.lo = full[15:0]; end
      5: begin
        sh   = int'(y % 16);
        full = x << sh;
        e.lo = full[15:0];
        if (sh != 0) begin
          full = (x >> (16 - sh)) & 32'd1;
          e.c  = full[0];
        end
      end
      6: begin
        full  = x * y;
        e.lo  = full[15:0];
        e.hi  = full[31:16];
        e.c   = (e.hi != 16'h0);
        e.lat = 17;
      end
      default: begin
`ifdef ALU_DIV_EN
        if (y == 0) begin
          e.lo = 16'hFFFF;
          e.hi = av;
          e.e  = 1'b1;
        end else begin
          full  = x / y;
          e.lo  = full[15:0];
          full  = x % y;
          e.hi  = full[15:0];
          e.lat = 17;
        end
`else
        e.e = 1'b1;
`endif
      end
    endcase
    e.z = (e.lo == 16'h0);
    return e;
  endfunction

  // Issue one operation, wait (bounded) for done, then compare everything.
  // poke_at: observation index at which a stray ADD start is driven (BUSY only).
  task automatic do_op(input int op, input logic [15:0] av, input logic [15:0] bv,
                       input int poke_at, input string tag);
    exp_t e;
    int   lat;
    int   busy_cnt;
    e = model(op, av, bv);
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'(op);
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = 3'($urandom);
    a      = 16'($urandom);
    b      = 16'($urandom);
    lat      = 1;
    busy_cnt = 0;
    if (e.lat > 1) check({tag, "_hold"}, 32'(result), 32'(last_lo));
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (lat == poke_at) begin
        start  = 1'b1;
        opcode = 3'd0;
        a      = 16'($urandom);
        b      = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"},  32'(done),      32'(1));
    check({tag, "_lat"},   32'(lat),       32'(e.lat));
    check({tag, "_busyn"}, 32'(busy_cnt),  32'(e.lat - 1));
    check({tag, "_busy0"}, 32'(busy),      32'(0));
    check({tag, "_res"},   32'(result),    32'(e.lo));
    check({tag, "_hi"},    32'(result_hi), 32'(e.hi));
    check({tag, "_zero"},  32'(zero),      32'(e.z));
    check({tag, "_carry"}, 32'(carry),     32'(e.c));
    check({tag, "_err"},   32'(err),       32'(e.e));
    last_lo = e.lo;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),      32'(0));
    check({tag, "_done"},  32'(done),      32'(0));
    check({tag, "_res"},   32'(result),    32'(0));
    check({tag, "_hi"},    32'(result_hi), 32'(0));
    check({tag, "_zero"},  32'(zero),      32'(0));
    check({tag, "_carry"}, 32'(carry),     32'(0));
    check({tag, "_err"},   32'(err),       32'(0));
  endtask

  initial begin
    int op;
    logic [15:0] av;
    logic [15:0] bv;

    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 3'd0;
    a       = 16'h0;
    b       = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    reset_n = 1'b1;

    // Directed cases
    do_op(0, 16'h000A, 16'h0005, 0, "add");
    do_op(1, 16'h0008, 16'h0010, 0, "sub");
    do_op(2, 16'hFFFF, 16'h0000, 0, "and_b2b");
    do_op(5, 16'h8001, 16'h0001, 0, "shl1");
    do_op(5, 16'h1234, 16'h0000, 0, "shl0");
    do_op(0, 16'hFFFF, 16'h0001, 0, "add_cy");
    do_op(6, 16'h00FF, 16'h000F, 5, "mul");
    @(posedge clk);
    #1;
    check("mul_poke_idle", 32'(done), 32'(0));
    do_op(6, 16'hFFFF, 16'hFFFF, 9, "mul_max");
    do_op(7, 16'h0030, 16'h0010, 3, "div");
    do_op(7, 16'h0030, 16'h0000, 0, "div0");
    do_op(7, 16'hFFFF, 16'h0007, 0, "div_b");

    // Reset in the middle of a multiply
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'd6;
    a      = 16'h1234;
    b      = 16'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("rstmid_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rstmid");
    reset_n = 1'b1;
    last_lo = 16'h0;
    do_op(0, 16'h4000, 16'h0123, 0, "add_after_rst");
    repeat (20) begin
      @(posedge clk);
      #1;
      check("rstmid_nodone", 32'(done), 32'(0));
    end

    // Randomized operations, mostly back-to-back
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      av = 16'($urandom);
      bv = 16'($urandom);
      if (op == 7 && $urandom_range(0, 3) == 0) bv = 16'h0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_op(op, av, bv, int'($urandom_range(1, 14)), $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
